uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Packet-granular round-robin arbiter that shares the single UART transmit byte stream between `NUM_SOURCES` requesters in the peripherals top level. Each requester offers AXI-Stream bytes framed by `tlast`. The arbiter grants one requester at a time, holds that grant until the packet's `tlast` beat is accepted, and forwards bytes through a registered skid stage to the `uart` transmit sink. A beat limit stops a stuck or unterminated requester from starving the others.

## Interface

Parameters:
- `NUM_SOURCES`, default 4: number of requesters; must be 2..16.
- `DATA_WIDTH`, default 8: byte width, matching the UART stream.
- `MAX_BEATS`, default 256: maximum beats accepted per grant before forced release; must be ≥1.

Ports:
- `clk`, in, 1: system clock (clk_100 domain).
- `reset_n`, in, 1: synchronous, active-low reset.
- `s_tdata`, in, `NUM_SOURCES`×`DATA_WIDTH`: requester data, packed with source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_tvalid`, in, `NUM_SOURCES`: requester valid.
- `s_tlast`, in, `NUM_SOURCES`: requester end-of-packet.
- `s_tready`, out, `NUM_SOURCES`: per-requester ready; at most one bit high.
- `m_tdata`, out, `DATA_WIDTH`: stream to UART tx sink.
- `m_tvalid`, out, 1: output valid.
- `m_tlast`, out, 1: output end-of-packet, forwarded unchanged.
- `m_tready`, in, 1: UART tx ready.
- `grant_idx`, out, clog2(`NUM_SOURCES`): current or last granted source.
- `grant_active`, out, 1: a grant is held.
- `overrun`, out, 1: one-cycle pulse when a grant is force-released at `MAX_BEATS`.

## Operation

- FSM states:
  - `IDLE`: no grant held.
  - `GRANTED`: grant locked to `grant_idx`.
- `IDLE` to `GRANTED`:
  - Any `s_tvalid` bit high selects the first requester with valid set, searching from `(last_idx+1) mod NUM_SOURCES` upward with wrap.
  - The selected index is registered into `grant_idx`, `grant_active` goes to 1, and `beat_cnt` goes to 0.
  - After reset `last_idx` = `NUM_SOURCES-1`, so source 0 has first priority.
- In `GRANTED`:
  - `s_tready[grant_idx]` = skid-stage input ready; all other `s_tready` bits = 0.
  - Skid input = {`s_tdata[g]`, `s_tlast[g]`}, with valid = `s_tvalid[g]`.
- Beat accepted (`s_tvalid[g] && s_tready[g]`): `beat_cnt` increments.
- Release to `IDLE` on an accepted beat when either:
  - that beat has `s_tlast` = 1, or
  - `beat_cnt` == `MAX_BEATS-1`. In this case `overrun` pulses in the following cycle and `m_tlast` is not altered.
  - On release, `last_idx` ← `g` and `grant_active` ← 0.
- No preemption:
  - A holder that drops `s_tvalid` mid-packet keeps the grant indefinitely, up to the beat limit.
  - Other requesters wait.
- Simultaneous events:
  - A release beat and a new request in the same cycle: the new grant is evaluated in the following `IDLE` cycle, never in the same cycle.
  - A requester asserting `s_tvalid` in the same cycle as release is eligible in the next cycle.
- Data integrity: bytes from different packets never interleave on `m_*`. The order within a packet is preserved.
- Reset values: `s_tready` = 0, `m_tvalid` = 0, `m_tdata` = 0, `m_tlast` = 0, `grant_active` = 0, `grant_idx` = 0, `overrun` = 0, state `IDLE`, `beat_cnt` = 0.
- Reset mid-packet: the grant is dropped, skid contents are discarded, and `m_tvalid` is 0 in the cycle after `reset_n` is sampled low.
- `beat_cnt` width is clog2(`MAX_BEATS`+1) and never wraps; it is cleared on every grant.

## Timing

- Arbitration latency is 1 cycle. With `s_tvalid[i]` rising at cycle 0 in `IDLE`, `s_tready[i]` rises at cycle 1, provided the skid is not full.
- Input-to-output latency is 1 cycle: a beat accepted at cycle n appears with `m_tvalid` at cycle n+1.
- Throughput is 1 beat/cycle within a packet while `m_tready` = 1. There is exactly one dead input cycle between packets, for re-arbitration.
- Skid stage: 2 entries, with `s_tready` driven from a register (no combinational `m_tready`→`s_tready` path).
- AXIS rules on `m_*`:
  - Once `m_tvalid` = 1, `m_tdata` and `m_tlast` stay stable until `m_tready`.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Stalls: while `m_tready` = 0, at most 2 beats are accepted before `s_tready[g]` falls.

## Structure

- Shared `peripherals_pkg` holds:
  - `arb_state_t` enum {`IDLE`, `GRANTED`}
  - `byte_t` typedef (logic [7:0])
  - the default `UART_MAX_BEATS` constant.
- Sub-module `axis_skid_buffer`, parameterized by `DATA_WIDTH`, carries {data, last}. It is reusable for the uart rx path.
- Round-robin priority search is a combinational function inside `uart_tx_arbiter`, not a separate module.

## Test plan

- Single source, `m_tready` = 1: source 2 sends 0x41, 0x42, 0x43 (last on 0x43). Required: `m_*` carries the same 3 beats with `m_tlast` on 0x43; `s_tready[2]` high at cycle 1; first `m_tvalid` at cycle 2; then `grant_active` = 0.
- Fairness: sources 0, 1 and 3 each continuously offer 2-byte packets. Required: grant order 0,1,3,0,1,3; no interleaving within any packet.
- Backpressure: 4-byte packet from source 1 with `m_tready` = 0 for 10 cycles. Required: exactly 2 beats accepted, then `s_tready[1]` = 0 and `m_tdata` stable; full packet delivered after release.
- Beat limit with `MAX_BEATS` = 4: source 0 streams 6 beats with no `tlast`. Required: 4 beats accepted, `overrun` pulses once, grant moves to waiting source 1, and source 0 is re-granted after source 1's packet.
- Reset mid-packet: assert `reset_n` = 0 after 2 of 5 beats. Required: next cycle `m_tvalid` = 0, all `s_tready` = 0, `grant_active` = 0; after release, source 0 wins first.

Source files
------------

// File: rtl/peripherals_pkg.sv
// Shared types and constants for the peripherals top level.
package peripherals_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  typedef logic [7:0] byte_t;

  localparam int UART_MAX_BEATS = 256;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice carrying {data, last}; in_ready and out_valid
// are both register-driven so there is no combinational path across the stage.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  skid_valid;
  logic                  in_fire;

  // The skid slot is only filled while the output is stalled, so an empty slot
  // always has room for one more beat.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_last   <= skid_last;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_data <= in_data;
          out_last <= in_last;
        end
      end
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_last  <= in_last;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART tx byte stream between
// several AXI-Stream requesters, with a per-grant beat limit against stuck sources.
module uart_tx_arbiter
  import peripherals_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_BEATS   = UART_MAX_BEATS
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0]            s_tvalid,
  input  logic [NUM_SOURCES-1:0]            s_tlast,
  output logic [NUM_SOURCES-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  input  logic                              m_tready,
  output logic [$clog2(NUM_SOURCES)-1:0]    grant_idx,
  output logic                              grant_active,
  output logic                              overrun
);

  localparam int IDX_W = $clog2(NUM_SOURCES);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef logic [IDX_W-1:0] idx_t;

  arb_state_t            state;
  idx_t                  last_idx;
  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_WIDTH-1:0] src_data [NUM_SOURCES];
  logic                  sel_valid;
  logic                  sel_last;
  logic                  skid_ready;
  logic                  beat_fire;
  logic                  limit_hit;

  // First requester with valid set, scanning upward from the one after last.
  function automatic idx_t rr_pick(input logic [NUM_SOURCES-1:0] req, input idx_t last);
    idx_t pick  = last;
    logic found = 1'b0;
    int   cand;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      cand = (int'(last) + k) % NUM_SOURCES;
      if (!found && req[cand]) begin
        pick  = idx_t'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
      assign src_data[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign s_tready[gi] = grant_active && (grant_idx == idx_t'(gi)) && skid_ready;
    end
  endgenerate

  assign sel_valid = grant_active && s_tvalid[grant_idx];
  assign sel_last  = s_tlast[grant_idx];
  assign beat_fire = sel_valid && skid_ready;
  assign limit_hit = (beat_cnt == CNT_W'(MAX_BEATS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant_idx    <= '0;
      grant_active <= 1'b0;
      last_idx     <= idx_t'(NUM_SOURCES - 1);
      beat_cnt     <= '0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (|s_tvalid) begin
            grant_idx    <= rr_pick(s_tvalid, last_idx);
            grant_active <= 1'b1;
            beat_cnt     <= '0;
            state        <= GRANTED;
          end
        end
        GRANTED: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            // A beat-limit release leaves tlast untouched; only the pulse marks it.
            if (sel_last || limit_hit) begin
              state        <= IDLE;
              grant_active <= 1'b0;
              last_idx     <= grant_idx;
              overrun      <= !sel_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (src_data[grant_idx]),
    .in_last   (sel_last),
    .in_valid  (sel_valid),
    .in_ready  (skid_ready),
    .out_data  (m_tdata),
    .out_last  (m_tlast),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

endmodule
